// File: rtl/multdiv_issue_ctrl_pkg.sv
// ============================================================================
// multdiv_issue_ctrl_pkg : shared decode constants, $rstatus codes, FSM states
// Revision: 1.0
// ============================================================================
`default_nettype none

package multdiv_issue_ctrl_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam int STATUS_REG_DEF = 30;
  localparam int MUL_EXC_DEF    = 4;
  localparam int DIV_EXC_DEF    = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    WRITE = 2'd2
  } md_state_e;

endpackage

`default_nettype wire

// File: rtl/multdiv_issue_ctrl_decode.sv
// ============================================================================
// multdiv_issue_ctrl_decode : combinational mul/div recognition and rd extract
// Revision: 1.0
// ============================================================================
`default_nettype none

module multdiv_issue_ctrl_decode
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [31:0]       instr_i,
  output logic              is_md_o,
  output logic              is_div_o,
  output logic [REG_AW-1:0] rd_o
);

  logic [4:0] w_alu_op;
  logic       w_unused_bits;

  assign w_alu_op      = instr_i[6:2];
  assign is_md_o       = (instr_i[31:27] == OP_RTYPE) &&
                         ((w_alu_op == ALU_MUL) || (w_alu_op == ALU_DIV));
  assign is_div_o      = (w_alu_op == ALU_DIV);
  assign rd_o          = REG_AW'(instr_i[26:22]);
  assign w_unused_bits = ^{instr_i[21:7], instr_i[1:0]};

endmodule

`default_nettype wire

// File: rtl/multdiv_issue_ctrl.sv
// ============================================================================
// multdiv_issue_ctrl : issues mul/div to the multdiv unit, raises stalls and
//                      arbitrates the result or $rstatus code onto writeback
// Revision: 1.0
// ============================================================================
`default_nettype none

module multdiv_issue_ctrl
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int TIMEOUT    = 64,
  parameter int STATUS_REG = STATUS_REG_DEF,
  parameter int MUL_EXC    = MUL_EXC_DEF,
  parameter int DIV_EXC    = DIV_EXC_DEF
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  input  logic [31:0]       in_instr_i,
  output logic              in_ready_o,
  input  logic [REG_AW-1:0] rd_srcA_i,
  input  logic [REG_AW-1:0] rd_srcB_i,
  output logic              hazard_stall_o,
  output logic              md_ctrl_MULT_o,
  output logic              md_ctrl_DIV_o,
  input  logic              md_resultRDY_i,
  input  logic              md_exception_i,
  input  logic [XLEN-1:0]   md_result_i,
  output logic              wb_valid_o,
  output logic [REG_AW-1:0] wb_reg_o,
  output logic [XLEN-1:0]   wb_data_o,
  input  logic              wb_ready_i,
  output logic              busy_o
);

  localparam int                TW          = $clog2(TIMEOUT);
  localparam logic [TW-1:0]     T_LAST      = TW'(TIMEOUT - 1);
  localparam logic [REG_AW-1:0] STATUS_ADDR = REG_AW'(STATUS_REG);

  md_state_e         state_q;
  logic [REG_AW-1:0] dest_q;
  logic              op_div_q;
  logic [TW-1:0]     timer_q;
  logic              mult_q;
  logic              div_q;
  logic [REG_AW-1:0] wb_reg_q;
  logic [XLEN-1:0]   wb_data_q;

  logic              w_is_md;
  logic              w_is_div;
  logic [REG_AW-1:0] w_rd;
  logic              w_issue;
  logic              w_dest_hit;
  logic              w_status_hit;
  logic [XLEN-1:0]   w_exc_code;

  multdiv_issue_ctrl_decode #(
    .REG_AW (REG_AW)
  ) u_decode (
    .instr_i  (in_instr_i),
    .is_md_o  (w_is_md),
    .is_div_o (w_is_div),
    .rd_o     (w_rd)
  );

  assign busy_o         = (state_q != IDLE);
  assign in_ready_o     = (state_q == IDLE) || ((state_q == WRITE) && wb_ready_i);
  assign w_issue        = in_valid_i && w_is_md && in_ready_o;
  assign w_exc_code     = op_div_q ? XLEN'(DIV_EXC) : XLEN'(MUL_EXC);

  // $rstatus is always treated as pending: any in-flight op may end in an exception write.
  assign w_dest_hit     = (dest_q != '0) && ((rd_srcA_i == dest_q) || (rd_srcB_i == dest_q));
  assign w_status_hit   = (rd_srcA_i == STATUS_ADDR) || (rd_srcB_i == STATUS_ADDR);
  assign hazard_stall_o = busy_o && ((in_valid_i && w_is_md && !in_ready_o) ||
                                     w_dest_hit || w_status_hit);

  assign md_ctrl_MULT_o = mult_q;
  assign md_ctrl_DIV_o  = div_q;
  assign wb_valid_o     = (state_q == WRITE);
  assign wb_reg_o       = wb_reg_q;
  assign wb_data_o      = wb_data_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      dest_q    <= '0;
      op_div_q  <= 1'b0;
      timer_q   <= '0;
      mult_q    <= 1'b0;
      div_q     <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
    end else begin
      mult_q <= 1'b0;
      div_q  <= 1'b0;
      case (state_q)
        IDLE, WRITE: begin
          if (w_issue) begin
            state_q  <= BUSY;
            dest_q   <= w_rd;
            op_div_q <= w_is_div;
            timer_q  <= '0;
            mult_q   <= !w_is_div;
            div_q    <= w_is_div;
          end else if ((state_q == WRITE) && wb_ready_i) begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          timer_q <= timer_q + 1'b1;
          // A result arriving on the watchdog's last cycle still wins.
          if (md_resultRDY_i) begin
            if (md_exception_i) begin
              state_q   <= WRITE;
              wb_reg_q  <= STATUS_ADDR;
              wb_data_q <= w_exc_code;
            end else if (dest_q == '0) begin
              state_q <= IDLE;
            end else begin
              state_q   <= WRITE;
              wb_reg_q  <= dest_q;
              wb_data_q <= md_result_i;
            end
          end else if (timer_q == T_LAST) begin
            state_q   <= WRITE;
            wb_reg_q  <= STATUS_ADDR;
            wb_data_q <= w_exc_code;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multdiv_issue_ctrl.sv
// ============================================================================
// tb_multdiv_issue_ctrl : scoreboard bench for the mul/div issue controller
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multdiv_issue_ctrl;

  localparam int TIMEOUT = 64;

  typedef struct {
    logic [4:0]  rg;
    logic [31:0] data;
  } wb_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic [4:0]  rd_srcA, rd_srcB;
  logic        hazard;
  logic        mult, div;
  logic        md_rdy, md_exc;
  logic [31:0] md_res;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        busy;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  wbr_manual = 1'b0;
  bit  exp_pulse[$];
  wb_t exp_wb[$];

  multdiv_issue_ctrl dut (
    .clock_i        (clock),
    .reset_i        (reset),
    .in_valid_i     (in_valid),
    .in_instr_i     (in_instr),
    .in_ready_o     (in_ready),
    .rd_srcA_i      (rd_srcA),
    .rd_srcB_i      (rd_srcB),
    .hazard_stall_o (hazard),
    .md_ctrl_MULT_o (mult),
    .md_ctrl_DIV_o  (div),
    .md_resultRDY_i (md_rdy),
    .md_exception_i (md_exc),
    .md_result_i    (md_res),
    .wb_valid_o     (wb_valid),
    .wb_reg_o       (wb_reg),
    .wb_data_o      (wb_data),
    .wb_ready_i     (wb_ready),
    .busy_o         (busy)
  );

  initial forever #10 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] enc(input bit is_div, input logic [4:0] rd);
    logic [14:0] mid;
    mid = 15'($urandom);
    return {5'b00000, rd, mid, is_div ? 5'b00111 : 5'b00110, 2'b11};
  endfunction

  task automatic push_wb(input logic [4:0] rg, input logic [31:0] data);
    wb_t t;
    t.rg   = rg;
    t.data = data;
    exp_wb.push_back(t);
  endtask

  // Expected writeback of one completed operation, from the rules alone.
  task automatic expect_result(input bit is_div, input logic [4:0] dest, input bit exc,
                               input logic [31:0] res);
    if (exc)              push_wb(5'd30, is_div ? 32'd5 : 32'd4);
    else if (dest != 5'd0) push_wb(dest, res);
  endtask

  // Called at posedge+1 with the controller idle.
  task automatic issue_op(input bit is_div, input logic [4:0] dest);
    in_valid = 1'b1;
    in_instr = enc(is_div, dest);
    #1 check("in_ready_idle", in_ready, 1);
    exp_pulse.push_back(is_div);
    tick();
    in_valid = 1'b0;
    in_instr = $urandom;
    check("mult_pulse", mult, !is_div);
    check("div_pulse", div, is_div);
    check("busy_after_issue", busy, 1);
  endtask

  // lat < 0 means the unit never answers and the watchdog must fire.
  task automatic finish_op(input int lat, input logic [4:0] dest, input bit is_div,
                           input bit exc, input logic [31:0] res);
    if (lat < 0) begin
      expect_result(is_div, dest, 1'b1, res);
      repeat (TIMEOUT - 1) tick();
      check("pre_timeout_wb", wb_valid, 0);
      tick();
      check("timeout_wb", wb_valid, 1);
    end else begin
      repeat (lat) tick();
      md_rdy = 1'b1;
      md_exc = exc;
      md_res = res;
      expect_result(is_div, dest, exc, res);
      tick();
      md_rdy = 1'b0;
      md_exc = 1'b0;
      md_res = $urandom;
      check("wb_after_rdy", wb_valid, exc || (dest != 5'd0));
      check("busy_after_rdy", busy, exc || (dest != 5'd0));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  initial begin
    wb_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!wbr_manual) wb_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares every presented pulse and writeback against the scoreboard.
  initial begin
    bit e;
    forever begin
      @(negedge clock);
      if (mult || div) begin
        check("pulse_both", mult & div, 0);
        if (exp_pulse.size() == 0) check("pulse_unexpected", mult | div, 0);
        else begin
          e = exp_pulse.pop_front();
          check("pulse_op", div, e);
        end
      end
      if (wb_valid) begin
        if (exp_wb.size() == 0) check("wb_unexpected", wb_valid, 0);
        else begin
          check("wb_reg", wb_reg, exp_wb[0].rg);
          check("wb_data", wb_data, exp_wb[0].data);
          if (wb_ready) void'(exp_wb.pop_front());
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    rd_srcA  = '0;
    rd_srcB  = '0;
    md_rdy   = 1'b0;
    md_exc   = 1'b0;
    md_res   = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_reg", wb_reg, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_pulses", {mult, div}, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_hazard", hazard, 0);
    reset = 1'b0;
    tick();

    // Non-mul/div instructions must not issue.
    in_valid = 1'b1;
    in_instr = {5'b00001, 5'd5, 15'h0, 5'b00110, 2'b11};
    tick();
    check("no_issue_opcode_hi", busy, 0);
    in_instr = {5'b00000, 5'd5, 15'h0, 5'b00101, 2'b11};
    tick();
    check("no_issue_alu_op", busy, 0);
    in_valid = 1'b0;

    // mul r5 = 42 with hazard probes, then a second mul waiting through a held WRITE.
    wbr_manual = 1'b1;
    wb_ready   = 1'b0;
    issue_op(1'b0, 5'd5);
    rd_srcA = 5'd5;  rd_srcB = 5'd6;  #1 check("haz_dest", hazard, 1);
    rd_srcA = 5'd6;  rd_srcB = 5'd30; #1 check("haz_status", hazard, 1);
    rd_srcA = 5'd6;  rd_srcB = 5'd7;  #1 check("haz_clear", hazard, 0);
    in_valid = 1'b1; in_instr = enc(1'b1, 5'd9);
    #1 check("haz_structural", hazard, 1);
    check("in_ready_busy", in_ready, 0);
    in_valid = 1'b0; rd_srcA = 5'd0; rd_srcB = 5'd0;
    finish_op(16, 5'd5, 1'b0, 1'b0, 32'd42);
    in_valid = 1'b1;
    in_instr = enc(1'b0, 5'd6);
    exp_pulse.push_back(1'b0);
    #1 check("in_ready_write_held", in_ready, 0);
    check("haz_write_held", hazard, 1);
    repeat (3) begin
      tick();
      check("wb_held", wb_valid, 1);
    end
    wb_ready = 1'b1;
    #1 check("in_ready_granted", in_ready, 1);
    tick();
    in_valid = 1'b0;
    wb_ready = 1'b0;
    check("b2b_mult_pulse", mult, 1);
    check("b2b_busy", busy, 1);
    check("b2b_wb_dropped", wb_valid, 0);
    finish_op(4, 5'd6, 1'b0, 1'b0, 32'h1234_5678);
    wbr_manual = 1'b0;
    wait_idle();
    rd_srcA = 5'd30;
    #1 check("haz_idle", hazard, 0);
    rd_srcA = 5'd0;

    // div r7 by zero -> $rstatus gets the div code.
    issue_op(1'b1, 5'd7);
    finish_op(3, 5'd7, 1'b1, 1'b1, 32'hdead_beef);
    wait_idle();

    // mul r0 -> no writeback at all.
    issue_op(1'b0, 5'd0);
    finish_op(5, 5'd0, 1'b0, 1'b0, 32'd9);
    tick();
    check("r0_idle", busy, 0);

    // Result on the watchdog's final cycle wins over the timeout.
    issue_op(1'b1, 5'd4);
    finish_op(TIMEOUT - 1, 5'd4, 1'b1, 1'b0, 32'h0bad_cafe);
    wait_idle();

    // Watchdog timeout, then spurious results in WRITE and IDLE.
    wbr_manual = 1'b1;
    wb_ready   = 1'b0;
    issue_op(1'b0, 5'd3);
    finish_op(-1, 5'd3, 1'b0, 1'b0, 32'd0);
    md_rdy = 1'b1; md_res = 32'd123;
    tick();
    md_rdy = 1'b0;
    check("spurious_write_wb", wb_valid, 1);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    check("timeout_done", busy, 0);
    md_rdy = 1'b1;
    tick();
    md_rdy = 1'b0;
    tick();
    check("spurious_idle_busy", busy, 0);
    check("spurious_idle_wb", wb_valid, 0);
    wbr_manual = 1'b0;

    // Reset mid-BUSY aborts without writeback.
    issue_op(1'b1, 5'd9);
    repeat (5) tick();
    reset = 1'b1;
    #1 check("abort_busy", busy, 0);
    check("abort_wb", wb_valid, 0);
    check("abort_pulses", {mult, div}, 0);
    tick();
    reset = 1'b0;
    md_rdy = 1'b1; md_res = 32'd77;
    tick();
    md_rdy = 1'b0;
    repeat (3) tick();
    check("abort_stays_idle", busy, 0);
    check("abort_no_wb", wb_valid, 0);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      bit          d;
      bit          ex;
      logic [4:0]  rd;
      int          lat;
      logic [31:0] res;
      d = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       rd = 5'd0;
        1:       rd = 5'd30;
        default: rd = 5'($urandom_range(1, 31));
      endcase
      lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 30));
      ex  = ($urandom_range(0, 3) == 0);
      res = $urandom;
      issue_op(d, rd);
      finish_op(lat, rd, d, ex, res);
      wait_idle();
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    check("pulse_q_empty", exp_pulse.size(), 0);
    check("wb_q_empty", exp_wb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
